// File: rtl/pio_cmd_pkg.sv
// Shared types and field geometry for the PIO command engine.
// Widths here describe the default 32-bit word; the engine derives its own from DATA_W.
package pio_cmd_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int OPND_W      = DATA_W_DFLT - 4;
    localparam int RES_W       = DATA_W_DFLT - 3;
    localparam int DIV_W       = 26;
    localparam logic [DIV_W-1:0] DIV_MAX = {DIV_W{1'b1}};

    typedef enum logic [2:0] {
        OP_ECHO   = 3'd0,
        OP_INC    = 3'd1,
        OP_ADD    = 3'd2,
        OP_CLR    = 3'd3,
        OP_RDACC  = 3'd4,
        OP_SETDIV = 3'd5,
        OP_DELAY  = 3'd6,
        OP_BAD    = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/led_blinker.sv
// Free-running LED blinker: toggles led every div clocks; a divisor load restarts the count.
module led_blinker
    import pio_cmd_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             led
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_led;

    // Divisor register, wrap counter and LED toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= DIV_W'(BLINK_DIV);
            r_cnt <= {DIV_W{1'b0}};
            r_led <= 1'b0;
        end else if (div_load) begin
            r_div <= div;
            r_cnt <= {DIV_W{1'b0}};
        end else if (r_cnt >= (r_div - {{(DIV_W-1){1'b0}}, 1'b1})) begin
            r_cnt <= {DIV_W{1'b0}};
            r_led <= ~r_led;
        end else begin
            r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    assign led = r_led;

endmodule

// File: rtl/pio_cmd_engine.sv
// HPS<->FPGA PIO command engine: toggle-handshake command decode, accumulator, delay, blinker.
// Define PIO_CMD_BLINK_EN to include the LED blinker and the SETDIV opcode.
module pio_cmd_engine
    import pio_cmd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BLINK_DIV = 25000000,
    parameter int DELAY_MAX = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pp_out,
    output logic [DATA_W-1:0] pp_in,
    output logic              led
);

    localparam int L_OPND_W = DATA_W - 4;
    localparam int L_RES_W  = DATA_W - 3;
    localparam int L_CNT_W  = $clog2(DELAY_MAX + 1);

    logic [DATA_W-1:0]   r_pp_q;
    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_last_req;
    opcode_e             r_opcode;
    logic [L_OPND_W-1:0] r_operand;
    logic [L_RES_W-1:0]  r_acc;
    logic [L_CNT_W-1:0]  r_dly_cnt;
    logic [L_CNT_W-1:0]  r_dly_tgt;
    logic [L_CNT_W-1:0]  w_dly_tgt;
    logic                r_ack;
    logic                r_busy;
    logic                r_err;
    logic [L_RES_W-1:0]  r_res;
    logic                w_req;
    logic                w_exec_done;
    logic [L_RES_W-1:0]  w_opnd_ext;
    logic [L_RES_W-1:0]  w_res;
    logic                w_err;

    assign w_req      = r_pp_q[DATA_W-1];
    assign w_opnd_ext = {1'b0, r_operand};

`ifdef PIO_CMD_BLINK_EN
    logic             w_div_ok;
    logic [DIV_W-1:0] w_div_val;
    logic             w_div_load;

    // Oversized divisors saturate to the counter range; zero is rejected.
    assign w_div_ok   = (r_operand != {L_OPND_W{1'b0}});
    assign w_div_val  = (32'(r_operand) > 32'(DIV_MAX)) ? DIV_MAX : DIV_W'(r_operand);
    assign w_div_load = w_exec_done && (r_opcode == OP_SETDIV) && w_div_ok;

    led_blinker #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blinker (
        .clk      (clk),
        .reset_n  (reset_n),
        .div      (w_div_val),
        .div_load (w_div_load),
        .led      (led)
    );
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_DIV > 0);
    assign led            = 1'b0;
`endif

    // Next-state logic; DELAY stays in EXEC until the wait count is reached.
    always_comb begin
        w_state_nxt = r_state;
        w_exec_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req != r_last_req) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CAPTURE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if ((r_opcode != OP_DELAY) || (r_dly_cnt == r_dly_tgt)) begin
                    w_exec_done = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturated delay wait length.
    always_comb begin
        if (32'(r_operand) > 32'(DELAY_MAX)) begin
            w_dly_tgt = L_CNT_W'(DELAY_MAX);
        end else begin
            w_dly_tgt = L_CNT_W'(r_operand);
        end
    end

    // Response value, evaluated in RESP after the accumulator has settled.
    always_comb begin
        w_res = {L_RES_W{1'b0}};
        w_err = 1'b0;
        case (r_opcode)
            OP_ECHO:  w_res = w_opnd_ext;
            OP_INC:   w_res = w_opnd_ext + {{(L_RES_W-1){1'b0}}, 1'b1};
            OP_ADD:   w_res = r_acc;
            OP_CLR:   w_res = {L_RES_W{1'b0}};
            OP_RDACC: w_res = r_acc;
`ifdef PIO_CMD_BLINK_EN
            OP_SETDIV: begin
                if (w_div_ok) begin
                    w_res = w_opnd_ext;
                end else begin
                    w_err = 1'b1;
                end
            end
`endif
            OP_DELAY: w_res = L_RES_W'(r_dly_cnt);
            default:  w_err = 1'b1;
        endcase
    end

    // State and input-capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pp_q  <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_pp_q  <= pp_out;
        end
    end

    // Command latch, delay counter, accumulator and PIO response word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_req <= 1'b0;
            r_opcode   <= OP_ECHO;
            r_operand  <= {L_OPND_W{1'b0}};
            r_acc      <= {L_RES_W{1'b0}};
            r_dly_cnt  <= {L_CNT_W{1'b0}};
            r_dly_tgt  <= {L_CNT_W{1'b0}};
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_res      <= {L_RES_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_CAPTURE) begin
                        r_last_req <= w_req;
                        r_opcode   <= opcode_e'(r_pp_q[DATA_W-2 -: 3]);
                        r_operand  <= r_pp_q[L_OPND_W-1:0];
                        r_busy     <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_dly_cnt <= {L_CNT_W{1'b0}};
                    r_dly_tgt <= w_dly_tgt;
                end
                ST_EXEC: begin
                    if (w_exec_done) begin
                        if (r_opcode == OP_ADD) begin
                            r_acc <= r_acc + w_opnd_ext;
                        end else if (r_opcode == OP_CLR) begin
                            r_acc <= {L_RES_W{1'b0}};
                        end
                    end else begin
                        r_dly_cnt <= r_dly_cnt + {{(L_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    r_ack  <= ~r_ack;
                    r_busy <= 1'b0;
                    r_err  <= w_err;
                    r_res  <= w_res;
                end
                default: ;
            endcase
        end
    end

    assign pp_in = {r_ack, r_busy, r_err, r_res};

endmodule
